red_pitaya_iq_demod_decim_block: RTL and testbench
==================================================

RED_PITAYA_IQ_DEMOD_DECIM_BLOCK -- requirements
Module: red_pitaya_iq_demod_decim_block

Interface
REQ-001 SHALL have parameters: INBITS, 14, signal width; SINBITS, 14, LO width; OUTBITS, 18, output width; SHIFTBITS, 1, MSB drop; CHANNELS, 2, LO pairs; DECBITS_MAX, 8, max log2 decimation.
REQ-002 SHALL have ports: clk_i in 1 clock; rstn_i in 1 reset; signal_i in INBITS signed input.
REQ-003 SHALL have ports: sin_i, cos_i in CHANNELS*SINBITS, packed signed LO, channel k at [k*SINBITS+:SINBITS].
REQ-004 SHALL have ports: valid_i in 1 sample strobe; clear_i in 1 sync flush; dec_log2_i in 4 log2 decimation; round_mode_i in 2 rounding select.
REQ-005 SHALL have ports: signal1_o, signal2_o out CHANNELS*OUTBITS, packed signed sin/cos results; valid_o out 1 result strobe; overflow_o out 1 sticky saturation flag.
REQ-006 SHALL use one clock, clk_i; rstn_i SHALL be asynchronous, active-low.

Function
REQ-007 SHALL register signal_i, sin_i, cos_i, valid_i in stage 1; form W=SINBITS+INBITS full products per channel in stage 2.
REQ-008 SHALL accumulate stage-2 products only on valid samples, into W+DECBITS_MAX-bit accumulators per channel and quadrature; counter holds while valid low.
REQ-009 SHALL latch D=min(dec_log2_i, DECBITS_MAX) at block start (first valid after reset, dump or clear); mid-block changes apply from next block.
REQ-010 SHALL dump after 2^D valid samples: sum arithmetic-shifted right by D, rounded, bits [W-1-SHIFTBITS : W-OUTBITS-SHIFTBITS] registered to outputs; accumulators and counter restart with no lost sample.
REQ-011 SHALL assert valid_o for one cycle per dump, 3 cycles after the valid_i completing the block; D=0 gives one result per valid_i at 3-cycle latency, full throughput.
REQ-012 SHALL hold outputs between dumps.
REQ-013 SHALL round per round_mode_i, R=W-OUTBITS-SHIFTBITS dropped LSBs: 0 truncate (floor); 1 and 3 add 2^(R-1) (half up); 2 half away from zero.
REQ-014 SHALL on clear_i zero accumulators, counter and stage-1/2 valids, clear overflow_o; clear_i wins over a coincident dump (no valid_o); outputs retain last values.
REQ-015 SHALL evaluate channels in parallel with identical timing.

Reset
REQ-016 SHALL on rstn_i low immediately zero all pipeline registers, accumulators, counter, signal1_o, signal2_o, valid_o, overflow_o, and latched D.
REQ-017 SHALL on reset release mid-block start a new block at the first valid_i; no partial result emitted.

Configuration
REQ-018 SHALL use macro IQ_DEMOD_DECIM_SAT_EN: defined, rounded results beyond OUTBITS signed range clamp to +2^(OUTBITS-1)-1 / -2^(OUTBITS-1) and set overflow_o; undefined, results wrap (MSBs dropped) and overflow_o is 0.

Verification
REQ-019 Defaults, D=0, mode 1, signal_i=8191, sin ch0=8191 -> signal1_o ch0=131040, valid_o 3 cycles after valid_i.
REQ-020 D=0, signal_i=-1, sin=256, modes 0/1/2 -> -1 / 0 / -1.
REQ-021 D=2, mode 0, 8 valid samples signal_i=4096, cos ch1=4096, valid gaps -> two valid_o pulses, signal2_o ch1=32768 each.
REQ-022 signal_i=-8192, sin=-8192, D=0 -> SAT_EN: 131071, overflow_o=1 until clear_i; without: -131072, overflow_o=0.
REQ-023 D=3, clear_i after 5 valid samples, 8 more -> exactly one valid_o, only post-clear samples; rstn_i low mid-block -> outputs 0 at once, no pulse.

Source files
------------

// File: rtl/red_pitaya_iq_demod_decim_block.sv
// rtl/red_pitaya_iq_demod_decim_block.sv - IQ demodulator with power-of-two accumulate-and-dump decimation
// Optional saturation of the output stage: define IQ_DEMOD_DECIM_SAT_EN.
module red_pitaya_iq_demod_decim_block #(
  parameter int INBITS      = 14,
  parameter int SINBITS     = 14,
  parameter int OUTBITS     = 18,
  parameter int SHIFTBITS   = 1,
  parameter int CHANNELS    = 2,
  parameter int DECBITS_MAX = 8
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [INBITS-1:0]            signal_i,
  input  logic [CHANNELS*SINBITS-1:0]  sin_i,
  input  logic [CHANNELS*SINBITS-1:0]  cos_i,
  input  logic                         valid_i,
  input  logic                         clear_i,
  input  logic [3:0]                   dec_log2_i,
  input  logic [1:0]                   round_mode_i,
  output logic [CHANNELS*OUTBITS-1:0]  signal1_o,
  output logic [CHANNELS*OUTBITS-1:0]  signal2_o,
  output logic                         valid_o,
  output logic                         overflow_o
);

  localparam int W  = SINBITS + INBITS;
  localparam int AW = W + DECBITS_MAX;
  localparam int R  = W - OUTBITS - SHIFTBITS;
  localparam int CW = DECBITS_MAX + 1;
  localparam logic signed [AW:0] HALF    = (AW+1)'((2**R) / 2);
  localparam logic signed [AW:0] HALF_M1 = (AW+1)'(((2**R) / 2) - ((R > 0) ? 1 : 0));

  logic signed [INBITS-1:0]        sig_q;
  logic [CHANNELS*SINBITS-1:0]     sin_q, cos_q;
  logic                            v1, v2;
  logic [3:0]                      d1, d2, d_lat;
  logic signed [W-1:0]             ps [CHANNELS];
  logic signed [W-1:0]             pc [CHANNELS];
  logic signed [AW-1:0]            acc_s [CHANNELS];
  logic signed [AW-1:0]            acc_c [CHANNELS];
  logic [CW-1:0]                   cnt;

  logic [3:0]                      d_in, d_eff;
  logic                            last;
  logic signed [W-1:0]             ps_n [CHANNELS];
  logic signed [W-1:0]             pc_n [CHANNELS];
  logic signed [AW-1:0]            sum_s [CHANNELS];
  logic signed [AW-1:0]            sum_c [CHANNELS];
  logic [OUTBITS:0]                r_s [CHANNELS];
  logic [OUTBITS:0]                r_c [CHANNELS];
  logic                            ovf_any;

  // Returns {overflow, result}: shift by D, round, drop R LSBs, fit to OUTBITS.
  function automatic logic [OUTBITS:0] finish_sum(input logic signed [AW-1:0] sum,
                                                  input logic [3:0] d,
                                                  input logic [1:0] mode);
    logic signed [AW:0] sh, rnd, q;
    logic               ovf;
    sh = (AW+1)'(sum) >>> d;
    case (mode)
      2'd0:    rnd = sh;
      2'd2:    rnd = sh + (sh[AW] ? HALF_M1 : HALF);
      default: rnd = sh + HALF;
    endcase
    q   = rnd >>> R;
    ovf = ~((&q[AW:OUTBITS-1]) | ~(|q[AW:OUTBITS-1]));
`ifdef IQ_DEMOD_DECIM_SAT_EN
    if (ovf)
      return {1'b1, q[AW] ? {1'b1, {(OUTBITS-1){1'b0}}} : {1'b0, {(OUTBITS-1){1'b1}}}};
    return {1'b0, q[OUTBITS-1:0]};
`else
    return {1'b0 & ovf, q[OUTBITS-1:0]};
`endif
  endfunction

  always_comb begin
    d_in    = (dec_log2_i > 4'(DECBITS_MAX)) ? 4'(DECBITS_MAX) : dec_log2_i;
    // The first sample of a block carries its own decimation setting.
    d_eff   = (cnt == '0) ? d2 : d_lat;
    last    = (cnt == CW'((32'd1 << d_eff) - 32'd1));
    ovf_any = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      ps_n[k]  = W'(sig_q) * W'($signed(sin_q[k*SINBITS +: SINBITS]));
      pc_n[k]  = W'(sig_q) * W'($signed(cos_q[k*SINBITS +: SINBITS]));
      sum_s[k] = acc_s[k] + AW'(ps[k]);
      sum_c[k] = acc_c[k] + AW'(pc[k]);
      r_s[k]   = finish_sum(sum_s[k], d_eff, round_mode_i);
      r_c[k]   = finish_sum(sum_c[k], d_eff, round_mode_i);
      ovf_any  = ovf_any | r_s[k][OUTBITS] | r_c[k][OUTBITS];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sig_q      <= '0;
      sin_q      <= '0;
      cos_q      <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      d1         <= '0;
      d2         <= '0;
      d_lat      <= '0;
      cnt        <= '0;
      signal1_o  <= '0;
      signal2_o  <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        ps[k]    <= '0;
        pc[k]    <= '0;
        acc_s[k] <= '0;
        acc_c[k] <= '0;
      end
    end else begin
      sig_q   <= $signed(signal_i);
      sin_q   <= sin_i;
      cos_q   <= cos_i;
      d1      <= d_in;
      d2      <= d1;
      v1      <= valid_i & ~clear_i;
      v2      <= v1 & ~clear_i;
      valid_o <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        ps[k] <= ps_n[k];
        pc[k] <= pc_n[k];
      end
      if (clear_i) begin
        cnt        <= '0;
        overflow_o <= 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
          acc_s[k] <= '0;
          acc_c[k] <= '0;
        end
      end else if (v2) begin
        if (cnt == '0)
          d_lat <= d2;
        if (last) begin
          // Dump includes the current sample, so the next block starts clean.
          cnt        <= '0;
          valid_o    <= 1'b1;
          overflow_o <= overflow_o | ovf_any;
          for (int k = 0; k < CHANNELS; k++) begin
            acc_s[k] <= '0;
            acc_c[k] <= '0;
            signal1_o[k*OUTBITS +: OUTBITS] <= r_s[k][OUTBITS-1:0];
            signal2_o[k*OUTBITS +: OUTBITS] <= r_c[k][OUTBITS-1:0];
          end
        end else begin
          cnt <= cnt + 1'b1;
          for (int k = 0; k < CHANNELS; k++) begin
            acc_s[k] <= sum_s[k];
            acc_c[k] <= sum_c[k];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_iq_demod_decim_block.sv
// tb/tb_red_pitaya_iq_demod_decim_block.sv - directed self-checking bench for the IQ demod/decimator
module tb_red_pitaya_iq_demod_decim_block;

  logic        clk = 1'b0;
  logic        rstn;
  logic [13:0] signal_i;
  logic [27:0] sin_i, cos_i;
  logic        valid_i, clear_i;
  logic [3:0]  dec_log2_i;
  logic [1:0]  round_mode_i;
  logic [35:0] signal1_o, signal2_o;
  logic        valid_o, overflow_o;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int p0;

  always #5 clk = ~clk;

  red_pitaya_iq_demod_decim_block dut (
    .clk_i(clk), .rstn_i(rstn), .signal_i(signal_i), .sin_i(sin_i), .cos_i(cos_i),
    .valid_i(valid_i), .clear_i(clear_i), .dec_log2_i(dec_log2_i), .round_mode_i(round_mode_i),
    .signal1_o(signal1_o), .signal2_o(signal2_o), .valid_o(valid_o), .overflow_o(overflow_o)
  );

  always @(negedge clk) if (valid_o === 1'b1) pulses++;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int sig, input int s0, input int s1, input int c0, input int c1);
    signal_i = 14'(sig);
    sin_i    = {14'(s1), 14'(s0)};
    cos_i    = {14'(c1), 14'(c0)};
  endtask

  // Single valid strobe from the current negedge; returns at the negedge where valid_o should be up.
  task automatic sample_and_wait;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  function automatic logic signed [63:0] s1(input int ch);
    return 64'($signed(signal1_o[ch*18 +: 18]));
  endfunction

  function automatic logic signed [63:0] s2(input int ch);
    return 64'($signed(signal2_o[ch*18 +: 18]));
  endfunction

  int exp_rnd [3] = '{-1, 0, -1};

  initial begin
    rstn = 1'b0; valid_i = 1'b0; clear_i = 1'b0; dec_log2_i = 4'd0; round_mode_i = 2'd1;
    set_in(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_sig1", 64'(signal1_o), 64'd0);
    chk("rst_sig2", 64'(signal2_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Full-scale product, D=0, half-up rounding, exact 3-cycle latency
    set_in(8191, 8191, 0, 0, 0);
    valid_i = 1'b1;
    @(negedge clk); valid_i = 1'b0;
    @(negedge clk);
    chk("lat_early", 64'(valid_o), 64'd0);
    @(negedge clk);
    chk("lat_valid", 64'(valid_o), 64'd1);
    chk("fs_ch0", s1(0), 64'sd131040);
    chk("fs_ch1", s1(1), 64'sd0);
    chk("fs_cos0", s2(0), 64'sd0);
    @(negedge clk);
    chk("pulse_width", 64'(valid_o), 64'd0);
    chk("hold", s1(0), 64'sd131040);

    // Rounding modes on an exact -0.5 LSB result
    for (int m = 0; m < 3; m++) begin
      round_mode_i = 2'(m);
      set_in(-1, 256, 0, 0, 0);
      sample_and_wait();
      chk("rnd_valid", 64'(valid_o), 64'd1);
      chk($sformatf("rnd_mode%0d", m), s1(0), 64'(exp_rnd[m]));
      @(negedge clk);
    end

    // D=2 with irregular gaps: dump on every 4th sample
    dec_log2_i = 4'd2; round_mode_i = 2'd0;
    p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      set_in(4096, 0, 0, 0, 4096);
      sample_and_wait();
      if (i % 4 == 3) begin
        chk("dec4_valid", 64'(valid_o), 64'd1);
        chk("dec4_cos1", s2(1), 64'sd32768);
        chk("dec4_sin0", s1(0), 64'sd0);
      end else begin
        chk("dec4_novalid", 64'(valid_o), 64'd0);
      end
      repeat (i % 2) @(negedge clk);
    end
    @(negedge clk);
    chk("dec4_pulses", 64'(pulses - p0), 64'd2);

    // Most negative squared: saturate or wrap, sticky overflow until clear
    dec_log2_i = 4'd0; round_mode_i = 2'd1;
    set_in(-8192, -8192, 0, 0, 0);
    sample_and_wait();
`ifdef IQ_DEMOD_DECIM_SAT_EN
    chk("sat_val", s1(0), 64'sd131071);
    chk("sat_ovf", 64'(overflow_o), 64'd1);
`else
    chk("wrap_val", s1(0), -64'sd131072);
    chk("wrap_ovf", 64'(overflow_o), 64'd0);
`endif
    @(negedge clk);
    set_in(100, 100, 0, 0, 0);
    sample_and_wait();
    chk("small_val", s1(0), 64'sd20);
`ifdef IQ_DEMOD_DECIM_SAT_EN
    chk("ovf_sticky", 64'(overflow_o), 64'd1);
`else
    chk("ovf_sticky", 64'(overflow_o), 64'd0);
`endif
    clear_i = 1'b1;
    @(negedge clk); clear_i = 1'b0;
    chk("clr_ovf", 64'(overflow_o), 64'd0);
    chk("clr_keep", s1(0), 64'sd20);

    // Clear coinciding with a dump suppresses it
    p0 = pulses;
    set_in(4096, 4096, 0, 0, 0);
    valid_i = 1'b1;
    @(negedge clk); valid_i = 1'b0;
    @(negedge clk); clear_i = 1'b1;
    @(negedge clk); clear_i = 1'b0;
    chk("clr_win_valid", 64'(valid_o), 64'd0);
    @(negedge clk);
    chk("clr_win_pulses", 64'(pulses - p0), 64'd0);
    chk("clr_win_keep", s1(0), 64'sd20);

    // D=3: partial block flushed by clear, then one full block
    dec_log2_i = 4'd3; round_mode_i = 2'd0;
    set_in(1000, 1000, 0, 0, 0);
    valid_i = 1'b1;
    repeat (5) @(negedge clk);
    valid_i = 1'b0;
    repeat (3) @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk); clear_i = 1'b0;
    p0 = pulses;
    set_in(4096, 2048, 0, 0, 0);
    valid_i = 1'b1;
    repeat (8) @(negedge clk);
    valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("blk8_valid", 64'(valid_o), 64'd1);
    chk("blk8_val", s1(0), 64'sd16384);
    @(negedge clk);
    chk("blk8_pulses", 64'(pulses - p0), 64'd1);

    // Asynchronous reset mid-block
    set_in(1000, 1000, 0, 0, 0);
    valid_i = 1'b1;
    repeat (3) @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_sig1", 64'(signal1_o), 64'd0);
    chk("arst_valid", 64'(valid_o), 64'd0);
    chk("arst_ovf", 64'(overflow_o), 64'd0);
    @(negedge clk); rstn = 1'b1;
    p0 = pulses;
    set_in(4096, 2048, 0, 0, 0);
    valid_i = 1'b1;
    repeat (8) @(negedge clk);
    valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_valid", 64'(valid_o), 64'd1);
    chk("post_rst_val", s1(0), 64'sd16384);
    @(negedge clk);
    chk("post_rst_pulses", 64'(pulses - p0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
